// File: rtl/pwm_sample_sched.sv
// Frame scheduler for the PWM sample path.
// Buffers up to two signed samples, converts each to magnitude/sign when it is
// popped, and presents one sample per FRAME_LEN-clock frame to the delay/PWM
// stage with a one-cycle frame_start strobe. A frame boundary that finds the
// buffer empty raises a sticky underrun flag.
module pwm_sample_sched #(
    parameter int FRAME_LEN     = 256,
    parameter bit UNDERRUN_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic [15:0] val_out,
    output logic        sign_out,
    output logic        frame_start,
    output logic        underrun,
    input  logic        clr_underrun,
    output logic        running
);

    localparam logic [15:0] LAST_CNT = 16'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;

    // Two-entry sample buffer
    logic [15:0] fifo_mem_q [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q, count_d;
    logic        ready_q;

    // Output registers
    logic [15:0] val_q, val_d;
    logic        sign_q, sign_d;
    logic        fs_q, fs_d;
    logic        underrun_q;
    logic        set_underrun;

    logic        push;
    logic        pop;
    logic [15:0] head;
    logic [15:0] head_mag;
    logic        head_sign;
    logic        boundary;

    // in_ready comes from a register so upstream never sees a path from in_valid
    assign push      = in_valid & ready_q;
    assign head      = fifo_mem_q[rd_ptr_q];
    assign head_sign = head[15];
    // No saturation: 0x8000 maps to magnitude 0x8000 with sign 1
    assign head_mag  = head_sign ? (~head + 16'd1) : head;
    assign boundary  = (cnt_q == LAST_CNT);
    assign count_d   = count_q + {1'b0, push} - {1'b0, pop};

    // State and frame counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: en is only honoured at frame boundaries once running
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en) state_d = S_PRIME;
            S_PRIME: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (count_q != 2'd0) begin
                    state_d = S_RUN;
                end
            end
            S_RUN:   if (boundary && !en) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Per-state datapath decisions: counter, pop, next output values, strobe
    always_comb begin
        cnt_d        = cnt_q;
        pop          = 1'b0;
        val_d        = val_q;
        sign_d       = sign_q;
        fs_d         = 1'b0;
        set_underrun = 1'b0;
        case (state_q)
            S_IDLE: cnt_d = '0;
            S_PRIME: begin
                cnt_d = '0;
                if (en && count_q != 2'd0) begin
                    pop    = 1'b1;
                    val_d  = head_mag;
                    sign_d = head_sign;
                    fs_d   = 1'b1;
                end
            end
            S_RUN: begin
                if (boundary) begin
                    cnt_d = '0;
                    if (!en) begin
                        // Stopping: park the PWM at zero, keep buffered samples
                        val_d  = '0;
                        sign_d = 1'b0;
                    end else if (count_q != 2'd0) begin
                        pop    = 1'b1;
                        val_d  = head_mag;
                        sign_d = head_sign;
                        fs_d   = 1'b1;
                    end else begin
                        // A same-cycle push is not visible in count_q, so it waits a frame
                        set_underrun = 1'b1;
                        fs_d         = 1'b1;
                        if (UNDERRUN_ZERO) begin
                            val_d  = '0;
                            sign_d = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Buffer pointers, occupancy and registered ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
            ready_q <= (count_d != 2'd2);
        end
    end

    // Buffer storage; contents are don't-care while empty, so no reset
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= in_data;
    end

    // Output registers; underrun set wins over clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            val_q      <= '0;
            sign_q     <= 1'b0;
            fs_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            val_q  <= val_d;
            sign_q <= sign_d;
            fs_q   <= fs_d;
            if (set_underrun) begin
                underrun_q <= 1'b1;
            end else if (clr_underrun) begin
                underrun_q <= 1'b0;
            end
        end
    end

    assign in_ready    = ready_q;
    assign val_out     = val_q;
    assign sign_out    = sign_q;
    assign frame_start = fs_q;
    assign underrun    = underrun_q;
    assign running     = (state_q == S_RUN);

endmodule

// File: tb/tb_pwm_sample_sched.sv
// Directed testbench for pwm_sample_sched. Three instances share the input
// stimulus: FRAME_LEN=4 with zero-on-underrun (_z), FRAME_LEN=4 with
// hold-on-underrun (_h), and FRAME_LEN=8 with zero-on-underrun (_e).
module tb_pwm_sample_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        in_valid;
    logic [15:0] in_data;
    logic        clr_underrun;

    logic        rdy_z, sign_z, fs_z, ur_z, run_z;
    logic [15:0] val_z;
    logic        rdy_h, sign_h, fs_h, ur_h, run_h;
    logic [15:0] val_h;
    logic        rdy_e, sign_e, fs_e, ur_e, run_e;
    logic [15:0] val_e;

    int n_total = 0;
    int n_pass  = 0;
    int nacc;
    int dval;
    bit acc;

    always #5 clk = ~clk;

    pwm_sample_sched #(.FRAME_LEN(4), .UNDERRUN_ZERO(1'b1)) dut_z (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy_z),
        .in_data(in_data), .val_out(val_z), .sign_out(sign_z), .frame_start(fs_z),
        .underrun(ur_z), .clr_underrun(clr_underrun), .running(run_z)
    );

    pwm_sample_sched #(.FRAME_LEN(4), .UNDERRUN_ZERO(1'b0)) dut_h (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy_h),
        .in_data(in_data), .val_out(val_h), .sign_out(sign_h), .frame_start(fs_h),
        .underrun(ur_h), .clr_underrun(clr_underrun), .running(run_h)
    );

    pwm_sample_sched #(.FRAME_LEN(8), .UNDERRUN_ZERO(1'b1)) dut_e (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy_e),
        .in_data(in_data), .val_out(val_e), .sign_out(sign_e), .frame_start(fs_e),
        .underrun(ur_e), .clr_underrun(clr_underrun), .running(run_e)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clock edge for the FRAME_LEN=8 instance, advancing the pattern on acceptance
    task automatic tick8();
        acc = in_valid && rdy_e;
        tick();
        if (acc) begin
            dval++;
            nacc++;
            in_data = 16'(dval);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0; clr_underrun = 1'b0;
        dval = 0; nacc = 0; acc = 1'b0;

        // ---------------- reset state ----------------
        tick();
        chk("rst_val", val_z, 16'h0000);
        chk("rst_sign", sign_z, 1'b0);
        chk("rst_fs", fs_z, 1'b0);
        chk("rst_ur", ur_z, 1'b0);
        chk("rst_run", run_z, 1'b0);
        chk("rst_rdy", rdy_z, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_rdy", rdy_z, 1'b1);
        chk("idle_run", run_z, 1'b0);

        // ---------------- conversion, FRAME_LEN=4 ----------------
        en = 1'b1; in_valid = 1'b1; in_data = 16'h0005;
        tick();                                   // IDLE -> PRIME, push 0005
        chk("prime_run", run_z, 1'b0);
        in_data = 16'hFFFB;
        tick();                                   // PRIME -> RUN, pop 0005
        chk("f0_fs", fs_z, 1'b1);
        chk("f0_val", val_z, 16'h0005);
        chk("f0_sign", sign_z, 1'b0);
        chk("f0_run", run_z, 1'b1);
        in_data = 16'h8000;
        tick();                                   // push 8000, buffer full
        chk("full_rdy", rdy_z, 1'b0);
        chk("f0_fs_c1", fs_z, 1'b0);
        in_data = 16'h0000;
        tick();
        chk("full_rdy2", rdy_z, 1'b0);
        chk("f0_fs_c2", fs_z, 1'b0);
        tick();
        chk("f0_fs_c3", fs_z, 1'b0);
        tick();                                   // boundary: pop FFFB
        chk("f1_fs", fs_z, 1'b1);
        chk("f1_val", val_z, 16'h0005);
        chk("f1_sign", sign_z, 1'b1);
        chk("f1_rdy", rdy_z, 1'b1);
        tick();                                   // push 0000
        chk("f1_full_rdy", rdy_z, 1'b0);
        in_valid = 1'b0;
        tick(); chk("f1_fs_c2", fs_z, 1'b0);
        tick(); chk("f1_fs_c3", fs_z, 1'b0);
        tick();                                   // pop 8000
        chk("f2_fs", fs_z, 1'b1);
        chk("f2_val", val_z, 16'h8000);
        chk("f2_sign", sign_z, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("f2_fs_gap", fs_z, 1'b0);
        end
        tick();                                   // pop 0000
        chk("f3_fs", fs_z, 1'b1);
        chk("f3_val", val_z, 16'h0000);
        chk("f3_sign", sign_z, 1'b0);
        chk("f3_ur", ur_z, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("f3_fs_gap", fs_z, 1'b0);
        end
        tick();                                   // empty boundary -> underrun
        chk("ur_fs", fs_z, 1'b1);
        chk("ur_set", ur_z, 1'b1);
        chk("ur_val", val_z, 16'h0000);

        // ---------------- underrun clear / priority ----------------
        tick();
        chk("ur_sticky", ur_z, 1'b1);
        clr_underrun = 1'b1;
        tick();
        chk("ur_cleared", ur_z, 1'b0);
        clr_underrun = 1'b0;
        tick();
        clr_underrun = 1'b1;
        tick();                                   // set and clear together
        chk("ur_set_wins", ur_z, 1'b1);
        chk("ur_set_wins_fs", fs_z, 1'b1);
        clr_underrun = 1'b0;

        // ---------------- reset mid-frame with buffered samples ----------------
        in_valid = 1'b1; in_data = 16'h0011;
        tick();
        in_data = 16'h0022;
        tick();
        chk("rs_full", rdy_z, 1'b0);
        in_data = 16'h0033;
        tick();
        tick();                                   // boundary: pop 0011
        chk("rs_val", val_z, 16'h0011);
        chk("rs_fs", fs_z, 1'b1);
        tick();                                   // push 0033
        rst_n = 1'b0; in_valid = 1'b0;
        tick();
        chk("mid_rst_val", val_z, 16'h0000);
        chk("mid_rst_fs", fs_z, 1'b0);
        chk("mid_rst_ur", ur_z, 1'b0);
        chk("mid_rst_run", run_z, 1'b0);
        chk("mid_rst_rdy", rdy_z, 1'b0);
        rst_n = 1'b1; en = 1'b1;
        tick();                                   // IDLE -> PRIME
        chk("after_rst_rdy", rdy_z, 1'b1);
        tick();                                   // PRIME waits: buffer is empty
        chk("after_rst_empty_run", run_z, 1'b0);
        chk("after_rst_empty_fs", fs_z, 1'b0);
        en = 1'b0;
        tick();

        // ---------------- hold on underrun, then enable control ----------------
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        en = 1'b1; in_valid = 1'b1; in_data = 16'hFF00;
        tick();                                   // push FF00, PRIME
        in_valid = 1'b0;
        tick();                                   // pop FF00
        chk("h_f0_fs", fs_h, 1'b1);
        chk("h_f0_val", val_h, 16'h0100);
        chk("h_f0_sign", sign_h, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("h_f0_gap", fs_h, 1'b0);
        end
        tick();                                   // underrun, hold
        chk("h_ur_fs", fs_h, 1'b1);
        chk("h_ur_val", val_h, 16'h0100);
        chk("h_ur_sign", sign_h, 1'b1);
        chk("h_ur", ur_h, 1'b1);
        chk("z_ur_val", val_z, 16'h0000);
        chk("z_ur_sign", sign_z, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("h_f1_gap", fs_h, 1'b0);
        end
        tick();
        chk("h_f2_fs", fs_h, 1'b1);
        chk("h_f2_val", val_h, 16'h0100);
        chk("h_f2_sign", sign_h, 1'b1);

        in_valid = 1'b1; in_data = 16'h0007;
        tick();
        in_data = 16'h0009;
        tick();
        in_valid = 1'b0; en = 1'b0;               // drop en mid-frame
        tick();
        chk("en_mid_val", val_h, 16'h0100);
        chk("en_mid_sign", sign_h, 1'b1);
        chk("en_mid_run", run_h, 1'b1);
        tick();                                   // boundary with en=0
        chk("en_off_val", val_h, 16'h0000);
        chk("en_off_sign", sign_h, 1'b0);
        chk("en_off_run", run_h, 1'b0);
        chk("en_off_fs", fs_h, 1'b0);
        tick();
        chk("en_off_kept", rdy_h, 1'b0);
        en = 1'b1;
        tick();                                   // IDLE -> PRIME
        chk("en_prime_run", run_h, 1'b0);
        chk("en_prime_fs", fs_h, 1'b0);
        tick();                                   // PRIME -> RUN, pop 0007
        chk("en_run_fs", fs_h, 1'b1);
        chk("en_run_val", val_h, 16'h0007);
        chk("en_run_run", run_h, 1'b1);
        chk("en_run_rdy", rdy_h, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("en_run_gap", fs_h, 1'b0);
        end
        tick();
        chk("en_next_fs", fs_h, 1'b1);
        chk("en_next_val", val_h, 16'h0009);

        // ---------------- backpressure, FRAME_LEN=8 ----------------
        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        en = 1'b1; in_valid = 1'b1; dval = 1; in_data = 16'h0001;
        tick8();                                  // push 1
        tick8();                                  // pop 1, push 2
        chk("bp_f0_fs", fs_e, 1'b1);
        chk("bp_f0_val", val_e, 16'h0001);
        for (int f = 1; f <= 5; f++) begin
            nacc = 0;
            for (int i = 0; i < 7; i++) begin
                tick8();
                chk("bp_gap_fs", fs_e, 1'b0);
            end
            tick8();
            chk("bp_fs", fs_e, 1'b1);
            chk("bp_val", val_e, 32'(f + 1));
            chk("bp_sign", sign_e, 1'b0);
            chk("bp_accepts", 32'(nacc), 32'd1);
        end
        chk("bp_no_ur", ur_e, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
